// File: rtl/seq_mod_remainder.sv
// seq_mod_remainder
// -----------------
// Bit-serial modulo-MOD divider. An accepted WIDTH-bit unsigned operand is
// consumed MSB first, one bit per clock, by restoring division. Each step
// produces one quotient bit and the running remainder. The final remainder
// and the WIDTH-bit quotient slice are presented on the output side.
//
// Multi-word operands are handled by chaining. The remainder of the last
// completed word is kept in last_rem. A word accepted with in_chain=1 starts
// from last_rem instead of 0, so words fed most-significant first produce
// N mod MOD at the end. Each word's out_quo is the matching WIDTH-bit slice
// of N / MOD.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer holds valid and data until that
// edge. in_ready decodes IDLE and out_valid decodes DONE, both straight from
// the state register, so no combinational path exists from in_* to out_*.
// out_rem and out_quo are registers that do not change while out_valid=1.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   in_valid  operand present
//   in_ready  block can accept an operand (state IDLE)
//   in_data   WIDTH-bit unsigned operand word
//   in_chain  start from the last completed remainder instead of 0
//   out_valid result available (state DONE)
//   out_ready consumer accepts the result
//   out_rem   remainder, always < MOD
//   out_quo   quotient bits for this word
//
// Latency: out_valid rises WIDTH+1 rising edges after the accept edge,
// counting the accept edge as the first. That is WIDTH BUSY cycles.
// Throughput: at most one operand per WIDTH+2 cycles.

module seq_mod_remainder #(
    parameter int WIDTH = 16,
    parameter int MOD   = 7,
    parameter int RW    = $clog2(MOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_rem,
    output logic [WIDTH-1:0] out_quo
);

    // The bit counter must hold the value WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);

    // The modulus is at most 2^RW, so it fits in RW+1 bits, the trial width.
    localparam logic [RW:0]   MOD_T      = (RW + 1)'(MOD);
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] shift_q,    shift_d;
    logic [RW-1:0]    r_q,        r_d;
    logic [WIDTH-1:0] quo_q,      quo_d;
    logic [CW-1:0]    count_q,    count_d;
    logic [RW-1:0]    last_rem_q, last_rem_d;
    logic [RW-1:0]    out_rem_q,  out_rem_d;
    logic [WIDTH-1:0] out_quo_q,  out_quo_d;

    // One restoring-division step.
    // The trial value is t = 2r + b, where b is the next operand bit.
    // Because r < MOD, t < 2*MOD, so at most one subtraction of MOD is
    // needed to bring it back below MOD. That subtraction sets the
    // quotient bit.
    logic [RW:0]      t_step;
    logic             q_bit;
    logic [RW-1:0]    r_next;
    logic [WIDTH-1:0] quo_next;

    always_comb begin
        t_step   = {r_q, shift_q[WIDTH-1]};
        q_bit    = (t_step >= MOD_T);
        r_next   = q_bit ? RW'(t_step - MOD_T) : RW'(t_step);
        quo_next = {quo_q[WIDTH-2:0], q_bit};
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        r_d        = r_q;
        quo_d      = quo_q;
        count_d    = count_q;
        last_rem_d = last_rem_q;
        out_rem_d  = out_rem_q;
        out_quo_d  = out_quo_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    r_d     = in_chain ? last_rem_q : '0;
                    quo_d   = '0;
                    count_d = COUNT_INIT;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                r_d     = r_next;
                quo_d   = quo_next;
                count_d = count_q - COUNT_ONE;
                // The last operand bit is consumed this cycle. Publish the
                // result. The chain remainder changes only on completion.
                if (count_q == COUNT_ONE) begin
                    out_rem_d  = r_next;
                    out_quo_d  = quo_next;
                    last_rem_d = r_next;
                    state_d    = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            r_q        <= '0;
            quo_q      <= '0;
            count_q    <= '0;
            last_rem_q <= '0;
            out_rem_q  <= '0;
            out_quo_q  <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            r_q        <= r_d;
            quo_q      <= quo_d;
            count_q    <= count_d;
            last_rem_q <= last_rem_d;
            out_rem_q  <= out_rem_d;
            out_quo_q  <= out_quo_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_rem   = out_rem_q;
    assign out_quo   = out_quo_q;

endmodule

// File: tb/tb_seq_mod_remainder.sv
// Testbench for seq_mod_remainder.
// Three instances run side by side:
//   id 0: WIDTH=4,  MOD=7
//   id 1: WIDTH=16, MOD=7
//   id 2: WIDTH=16, MOD=10
// Expected values come from whole-number arithmetic. A chained word's value
// is (previous remainder * 2^WIDTH + word).

module tb_seq_mod_remainder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  in_valid = '0;
  logic [2:0]  out_ready = '0;
  logic [15:0] in_data = '0;
  logic        in_chain = 1'b0;

  wire [2:0]   in_ready_w;
  wire [2:0]   out_valid_w;
  wire [2:0]   rem0;
  wire [3:0]   quo0;
  wire [2:0]   rem1;
  wire [15:0]  quo1;
  wire [3:0]   rem2;
  wire [15:0]  quo2;

  logic [15:0] rem_w [3];
  logic [15:0] quo_w [3];

  assign rem_w[0] = 16'(rem0);
  assign rem_w[1] = 16'(rem1);
  assign rem_w[2] = 16'(rem2);
  assign quo_w[0] = 16'(quo0);
  assign quo_w[1] = quo1;
  assign quo_w[2] = quo2;

  int checks = 0;
  int errors = 0;
  longint model_last [3];

  logic [15:0] exp_rem_q [$];
  logic [15:0] exp_quo_q [$];

  always #5 clk = ~clk;

  seq_mod_remainder #(.WIDTH(4), .MOD(7)) u_w4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .in_data(in_data[3:0]), .in_chain(in_chain),
    .out_valid(out_valid_w[0]), .out_ready(out_ready[0]),
    .out_rem(rem0), .out_quo(quo0)
  );

  seq_mod_remainder #(.WIDTH(16), .MOD(7)) u_w16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .in_data(in_data), .in_chain(in_chain),
    .out_valid(out_valid_w[1]), .out_ready(out_ready[1]),
    .out_rem(rem1), .out_quo(quo1)
  );

  seq_mod_remainder #(.WIDTH(16), .MOD(10)) u_m10 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .in_data(in_data), .in_chain(in_chain),
    .out_valid(out_valid_w[2]), .out_ready(out_ready[2]),
    .out_rem(rem2), .out_quo(quo2)
  );

  function automatic int width_of(input int id);
    return (id == 0) ? 4 : 16;
  endfunction

  function automatic int mod_of(input int id);
    return (id == 2) ? 10 : 7;
  endfunction

  // Reference model: whole-number division of the chained value.
  function automatic void model_op(input int id, input logic [15:0] data,
                                   input bit chain,
                                   output logic [15:0] er,
                                   output logic [15:0] eq);
    longint w    = longint'(width_of(id));
    longint m    = longint'(mod_of(id));
    longint d    = longint'(data) % (64'sd1 <<< w);
    longint base = chain ? model_last[id] : 0;
    longint comb = base * (64'sd1 <<< w) + d;
    er = 16'(comb % m);
    eq = 16'(comb / m);
    model_last[id] = comb % m;
  endfunction

  // Run one operation on instance id.
  // The consumer stalls for 'hold' cycles after out_valid rises. With
  // 'poke' set, one stray in_valid pulse is driven during the stall.
  task automatic do_op(input int id, input logic [15:0] data, input bit chain,
                       input logic [15:0] er, input logic [15:0] eq,
                       input int hold, input bit poke, input string name);
    int edges;
    int waitc;
    logic [15:0] seen_rem;
    logic [15:0] seen_quo;

    waitc = 0;
    @(negedge clk);
    while (in_ready_w[id] !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (in_ready_w[id] !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready timeout: got %b expected 1", name, in_ready_w[id]);
      return;
    end

    in_valid[id] = 1'b1;
    in_data = data;
    in_chain = chain;
    @(posedge clk);
    #1;
    in_valid[id] = 1'b0;
    in_chain = 1'b0;

    // The accept edge is the first of the WIDTH+1 edges, so WIDTH more follow.
    edges = 0;
    while (out_valid_w[id] !== 1'b1 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checks++;
    if (edges != width_of(id)) begin
      errors++;
      $display("FAIL %s latency: got %0d edges expected %0d", name, edges, width_of(id));
    end
    if (out_valid_w[id] !== 1'b1) return;

    checks++;
    if (rem_w[id] !== er) begin
      errors++;
      $display("FAIL %s rem: got %0d expected %0d", name, rem_w[id], er);
    end
    checks++;
    if (quo_w[id] !== eq) begin
      errors++;
      $display("FAIL %s quo: got %0d expected %0d", name, quo_w[id], eq);
    end

    seen_rem = rem_w[id];
    seen_quo = quo_w[id];
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 1) begin
        in_valid[id] = 1'b1;
        in_data = ~data;
      end
      @(posedge clk);
      #1;
      in_valid[id] = 1'b0;
      checks++;
      if (out_valid_w[id] !== 1'b1 || in_ready_w[id] !== 1'b0 ||
          rem_w[id] !== seen_rem || quo_w[id] !== seen_quo) begin
        errors++;
        $display("FAIL %s hold cycle %0d: got v=%b r=%b rem=%0d quo=%0d expected v=1 r=0 rem=%0d quo=%0d",
                 name, h, out_valid_w[id], in_ready_w[id], rem_w[id], quo_w[id], seen_rem, seen_quo);
      end
    end

    out_ready[id] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[id] = 1'b0;
    checks++;
    if (out_valid_w[id] !== 1'b0 || in_ready_w[id] !== 1'b1) begin
      errors++;
      $display("FAIL %s release: got v=%b r=%b expected v=0 r=1", name, out_valid_w[id], in_ready_w[id]);
    end

    if (poke) begin
      @(posedge clk);
      #1;
      checks++;
      if (in_ready_w[id] !== 1'b1 || out_valid_w[id] !== 1'b0) begin
        errors++;
        $display("FAIL %s stray pulse: got r=%b v=%b expected r=1 v=0", name, in_ready_w[id], out_valid_w[id]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int id = 0; id < 3; id++) begin
      checks++;
      if (in_ready_w[id] !== 1'b1 || out_valid_w[id] !== 1'b0 ||
          rem_w[id] !== 16'd0 || quo_w[id] !== 16'd0) begin
        errors++;
        $display("FAIL reset id%0d: got r=%b v=%b rem=%0d quo=%0d expected r=1 v=0 rem=0 quo=0",
                 id, in_ready_w[id], out_valid_w[id], rem_w[id], quo_w[id]);
      end
      model_last[id] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_w4_exhaustive();
    logic [15:0] er;
    logic [15:0] eq;
    for (int x = 0; x < 16; x++) begin
      model_op(0, 16'(x), 1'b0, er, eq);
      do_op(0, 16'(x), 1'b0, er, eq, 0, 1'b0, "w4_all");
    end
  endtask

  task automatic test_directed();
    logic [15:0] er;
    logic [15:0] eq;
    do_op(1, 16'hFFFF, 1'b0, 16'd1, 16'd9362, 0, 1'b0, "ffff");
    model_op(1, 16'hFFFF, 1'b0, er, eq);
    do_op(1, 16'h0000, 1'b0, 16'd0, 16'd0, 0, 1'b0, "zero");
    model_op(1, 16'h0000, 1'b0, er, eq);
    do_op(1, 16'h0001, 1'b0, 16'd1, 16'd0, 0, 1'b0, "chain_w0");
    model_op(1, 16'h0001, 1'b0, er, eq);
    do_op(1, 16'h0000, 1'b1, 16'd2, 16'd9362, 0, 1'b0, "chain_w1");
    model_op(1, 16'h0000, 1'b1, er, eq);
  endtask

  task automatic test_mod10_backpressure();
    logic [15:0] er;
    logic [15:0] eq;
    do_op(2, 16'd12345, 1'b0, 16'd5, 16'd1234, 5, 1'b1, "mod10_hold");
    model_op(2, 16'd12345, 1'b0, er, eq);
  endtask

  // Random multi-word operands. The final remainder is also compared with
  // the full-length value reduced modulo MOD.
  task automatic test_random_chain();
    logic [15:0] er;
    logic [15:0] eq;
    logic [15:0] word;
    longint full;
    int nw;
    for (int rep = 0; rep < 6; rep++) begin
      for (int id = 1; id < 3; id++) begin
        nw = $urandom_range(1, 3);
        full = 0;
        for (int k = 0; k < nw; k++) begin
          word = 16'($urandom_range(0, 65535));
          full = (full << 16) + longint'(word);
          model_op(id, word, k != 0, er, eq);
          do_op(id, word, k != 0, er, eq, $urandom_range(0, 3), 1'b0, "rand_chain");
        end
        checks++;
        if (rem_w[id] !== 16'(full % longint'(mod_of(id)))) begin
          errors++;
          $display("FAIL full_mod id%0d: got %0d expected %0d", id, rem_w[id], full % longint'(mod_of(id)));
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] er;
    logic [15:0] eq;
    do_op(1, 16'd100, 1'b0, 16'd2, 16'd14, 0, 1'b0, "pre_reset");
    model_op(1, 16'd100, 1'b0, er, eq);
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_data = 16'($urandom_range(0, 65535));
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    checks++;
    if (in_ready_w[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy: got in_ready=%b expected 0", in_ready_w[1]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid_w[1] !== 1'b0 || in_ready_w[1] !== 1'b1 ||
        rem_w[1] !== 16'd0 || quo_w[1] !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got v=%b r=%b rem=%0d quo=%0d expected v=0 r=1 rem=0 quo=0",
               out_valid_w[1], in_ready_w[1], rem_w[1], quo_w[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int id = 0; id < 3; id++) model_last[id] = 0;
    do_op(1, 16'd20, 1'b1, 16'd6, 16'd2, 0, 1'b0, "post_reset_chain");
    model_op(1, 16'd20, 1'b1, er, eq);
  endtask

  task automatic test_back_to_back();
    logic [15:0] er;
    logic [15:0] eq;
    int n;
    int issued;
    int got;
    int last_acc;
    int cyc;
    n = 6;
    issued = 0;
    got = 0;
    last_acc = -1;
    cyc = 0;
    exp_rem_q.delete();
    exp_quo_q.delete();
    out_ready[1] = 1'b1;
    in_chain = 1'b0;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (out_valid_w[1] === 1'b1) begin
        checks++;
        if (exp_rem_q.size() == 0) begin
          errors++;
          $display("FAIL b2b unexpected result: got rem=%0d expected none", rem_w[1]);
        end else begin
          er = exp_rem_q.pop_front();
          eq = exp_quo_q.pop_front();
          if (rem_w[1] !== er || quo_w[1] !== eq) begin
            errors++;
            $display("FAIL b2b result %0d: got rem=%0d quo=%0d expected rem=%0d quo=%0d",
                     got, rem_w[1], quo_w[1], er, eq);
          end
        end
        got++;
      end
      if (in_ready_w[1] === 1'b1) begin
        if (issued < n) begin
          in_valid[1] = 1'b1;
          in_data = 16'($urandom_range(0, 65535));
          model_op(1, in_data, 1'b0, er, eq);
          exp_rem_q.push_back(er);
          exp_quo_q.push_back(eq);
          if (last_acc >= 0) begin
            checks++;
            if (cyc - last_acc != 18) begin
              errors++;
              $display("FAIL b2b spacing: got %0d cycles expected 18", cyc - last_acc);
            end
          end
          last_acc = cyc;
          issued++;
        end else begin
          in_valid[1] = 1'b0;
        end
      end
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL b2b count: got %0d results expected %0d", got, n);
    end
  endtask

  initial begin
    test_reset();
    test_w4_exhaustive();
    test_directed();
    test_mod10_backpressure();
    test_random_chain();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
